// File: rtl/data_memory_ssd_pkg.sv
// Shared word width and seven-segment decode for the data memory / display slice.
package data_memory_ssd_pkg;

    localparam int unsigned WORD_SIZE = 16;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = '1;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic seg_t hex7(input logic [3:0] nib);
        seg_t code;
        case (nib)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/data_memory_ssd_driver.sv
// Four-digit multiplexed seven-segment driver: free-running refresh counter
// selects a nibble of val, anode/segment outputs registered.
module ssd_driver
    import data_memory_ssd_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 16
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic [15:0] val,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [REFRESH_BITS-1:0] CNT_ONE = 1;

    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0]              digit;
    logic [3:0]              nibble;

    assign digit  = cnt[REFRESH_BITS-1 -: 2];
    assign nibble = val[{digit, 2'b00} +: 4];
    assign dp     = 1'b1;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            cnt <= cnt + CNT_ONE;
            an  <= ~(4'b0001 << digit);
            seg <= hex7(nibble);
        end
    end

endmodule

// File: rtl/data_memory_ssd.sv
// Word-addressed data memory (sync write, gated combinational read) with an
// on-board seven-segment display of an arbitrary 16-bit value.
module data_memory_ssd
    import data_memory_ssd_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned REFRESH_BITS = 16
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] memaddr,
    input  logic [WORD_SIZE-1:0] memval,
    input  logic                 memget,
    input  logic                 memset,
    output logic [WORD_SIZE-1:0] memout,
    input  logic [15:0]          disp_val,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    // Contents survive rst_n; the initializer only sets the configuration image.
    logic [WORD_SIZE-1:0] mem [DEPTH] = '{default: '0};
    logic [ADDR_BITS-1:0] addr;
    logic                 unused_addr_hi;

    assign addr           = memaddr[ADDR_BITS-1:0];
    assign unused_addr_hi = ^memaddr[WORD_SIZE-1:ADDR_BITS];

    always_ff @(posedge mclk) begin
        if (memset && rst_n)
            mem[addr] <= memval;
    end

    assign memout = (memget && rst_n) ? mem[addr] : '0;

    ssd_driver #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_ssd (
        .mclk  (mclk),
        .rst_n (rst_n),
        .val   (disp_val),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

endmodule

// File: tb/tb_data_memory_ssd.sv
// Self-checking bench for data_memory_ssd: directed steps plus random traffic
// against an array/arithmetic reference model.
module tb_data_memory_ssd;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] memaddr = '0;
    logic [15:0] memval = '0;
    logic        memget = 1'b0;
    logic        memset = 1'b0;
    logic [15:0] memout;
    logic [15:0] disp_val = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference state
    logic [15:0] model_mem [256];
    int unsigned edges = 0;
    logic [15:0] disp_held = '0;
    logic [6:0]  hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    data_memory_ssd #(
        .ADDR_BITS    (8),
        .REFRESH_BITS (4)
    ) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .memaddr  (memaddr),
        .memval   (memval),
        .memget   (memget),
        .memset   (memset),
        .memout   (memout),
        .disp_val (disp_val),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the model's view of the coming edge, then advance to 1 ns after it.
    task automatic tick();
        if (rst_n && memset) model_mem[memaddr[7:0]] = memval;
        if (rst_n) begin
            edges++;
            disp_held = disp_val;
        end
        @(posedge mclk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_out;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        int unsigned d;
        exp_out = (memget && rst_n) ? model_mem[memaddr[7:0]] : 16'h0;
        if (edges == 0) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            d       = ((edges - 1) / 4) % 4;
            exp_an  = 4'hF ^ (4'h1 << d);
            exp_seg = hex_tab[(disp_held >> (4 * d)) & 16'hF];
        end
        chk({tag, ".memout"}, 32'(memout), 32'(exp_out));
        chk({tag, ".an"}, 32'(an), 32'(exp_an));
        chk({tag, ".seg"}, 32'(seg), 32'(exp_seg));
        chk({tag, ".dp"}, 32'(dp), 32'h1);
    endtask

    task automatic set_bus(input logic [15:0] a, input logic [15:0] v, input logic g, input logic s);
        memaddr = a;
        memval  = v;
        memget  = g;
        memset  = s;
        #1;
    endtask

    initial begin
        logic [15:0] rd;
        foreach (model_mem[i]) model_mem[i] = '0;

        // Reset state
        tick();
        tick();
        check_all("reset");
        chk("reset.an_const", 32'(an), 32'hF);
        chk("reset.seg_const", 32'(seg), 32'h7F);
        rst_n = 1'b1;

        // Writes with memget low, then idle, then reads
        set_bus(16'd1, 16'd1, 1'b0, 1'b1); check_all("wr1"); tick();
        set_bus(16'd2, 16'd4, 1'b0, 1'b1); check_all("wr2"); tick();
        set_bus(16'd3, 16'd9, 1'b0, 1'b1); check_all("wr3"); tick();
        set_bus(16'd0, 16'd0, 1'b0, 1'b0); tick(); tick();
        set_bus(16'd1, 16'd0, 1'b1, 1'b0); check_all("rd1"); chk("rd1.const", 32'(memout), 32'd1);
        set_bus(16'd2, 16'd0, 1'b1, 1'b0); check_all("rd2"); chk("rd2.const", 32'(memout), 32'd4);
        set_bus(16'd3, 16'd0, 1'b1, 1'b0); check_all("rd3"); chk("rd3.const", 32'(memout), 32'd9);

        // Read gating and write gating
        set_bus(16'd3, 16'hFFFF, 1'b0, 1'b0); check_all("get0"); tick();
        set_bus(16'd3, 16'hFFFF, 1'b1, 1'b0); check_all("nowrite");

        // Aliasing and same-cycle get+set
        set_bus(16'd1, 16'd5, 1'b0, 1'b1); tick();
        set_bus(16'h0101, 16'd0, 1'b1, 1'b0); check_all("alias"); chk("alias.const", 32'(memout), 32'd5);
        set_bus(16'd2, 16'd7, 1'b1, 1'b1); check_all("rmw.before"); chk("rmw.old", 32'(memout), 32'd4);
        tick(); check_all("rmw.after"); chk("rmw.new", 32'(memout), 32'd7);

        // Display scan of 0x1A09 across two full refresh periods
        set_bus(16'd0, 16'd0, 1'b0, 1'b0);
        disp_val = 16'h1A09;
        for (int i = 0; i < 32; i++) begin
            tick();
            check_all("scan");
        end

        // Mid-run reset pulse with a write attempt that must be blocked
        set_bus(16'd3, 16'h1234, 1'b1, 1'b1);
        rst_n = 1'b0;
        edges = 0;
        #1;
        check_all("rst_pulse");
        tick();
        check_all("rst_hold");
        rst_n = 1'b1;
        set_bus(16'd3, 16'd0, 1'b1, 1'b0); check_all("after_rst"); chk("after_rst.const", 32'(memout), 32'd9);
        tick(); check_all("first_digit"); chk("first_digit.an", 32'(an), 32'hE);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 0) a[7:3] = '0;
            set_bus(a, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 7) == 0) disp_val = 16'($urandom);
            #1;
            check_all("rand");
            tick();
        end

        // Display of memout minus expected: every digit must read 0
        foreach (model_mem[i]) begin
            if (i < 20) begin
                set_bus(16'(i), 16'd0, 1'b1, 1'b0);
                rd = memout - model_mem[i];
                disp_val = rd;
                tick();
                check_all("diff");
                if (edges > 1) chk("diff.zero", 32'(seg), 32'b1000000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
